// File: rtl/tnoc_packet_arbiter_pkg.sv
// Shared types for the packet arbiter: flit bit offsets, flit type and arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tnoc_packet_arbiter_pkg;

    localparam int FLIT_TYPE_BIT = 0;
    localparam int HEAD_BIT      = 1;
    localparam int TAIL_BIT      = 2;

    typedef enum logic {
        FLIT_HEADER  = 1'b0,
        FLIT_PAYLOAD = 1'b1
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tnoc_round_robin_picker.sv
// One-hot round-robin winner: search starts at ptr, wraps modulo N, first request wins.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module tnoc_round_robin_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/tnoc_packet_arbiter.sv
// Packet-granular round-robin arbiter; optional output skid slice under TNOC_PACKET_ARBITER_OUTPUT_SLICE_EN.
// Latency: first flit 1 cycle after eligible valid (2 with slice); one idle bubble after each tail.
// Backpressure: valid/ready; owner's o_ready follows i_ready (slice: slice-not-full), others held at 0.
module tnoc_packet_arbiter
    import tnoc_packet_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int FLIT_WIDTH = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [REQUESTERS-1:0]            i_valid,
    output logic [REQUESTERS-1:0]            o_ready,
    input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    output logic [REQUESTERS-1:0]            o_grant,
    output logic                             o_busy
);

    localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    arb_state_e              state;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           winner;
    logic [IW-1:0]           ptr_next;
    logic [REQUESTERS-1:0]   pick;
    // One-hot owner register; zero whenever no packet is locked.
    logic [REQUESTERS-1:0]   grant_q;
    logic [FLIT_WIDTH-1:0]   owner_flit;
    logic                    owner_vld;
    logic                    owner_acc;

    tnoc_round_robin_picker #(
        .N  (REQUESTERS),
        .IW (IW)
    ) u_picker (
        .req    (i_valid),
        .ptr    (ptr),
        .grant  (pick),
        .winner (winner)
    );

    assign ptr_next = (winner == IW'(REQUESTERS-1)) ? '0 : winner + 1'b1;

    always_comb begin
        owner_flit = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (grant_q[k]) begin
                owner_flit = i_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    assign owner_vld = |(i_valid & grant_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant_q <= '0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_valid) begin
                        state   <= LOCKED;
                        grant_q <= pick;
                        ptr     <= ptr_next;
                        o_busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (owner_vld && owner_acc && owner_flit[TAIL_BIT]) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TNOC_PACKET_ARBITER_OUTPUT_SLICE_EN
    logic [FLIT_WIDTH-1:0] slice_flit  [2];
    logic [REQUESTERS-1:0] slice_grant [2];
    logic [1:0]            slice_cnt;
    logic                  slice_wr_ptr;
    logic                  slice_rd_ptr;
    logic                  slice_full;
    logic                  slice_wr;
    logic                  slice_rd;

    // Two entries let the owner keep streaming while a stalled flit waits downstream.
    assign slice_full = (slice_cnt == 2'd2);
    assign owner_acc  = !slice_full;
    assign slice_wr   = owner_vld && !slice_full;
    assign slice_rd   = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slice_cnt    <= '0;
            slice_wr_ptr <= 1'b0;
            slice_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slice_flit[i]  <= '0;
                slice_grant[i] <= '0;
            end
        end else begin
            if (slice_wr) begin
                slice_flit[slice_wr_ptr]  <= owner_flit;
                slice_grant[slice_wr_ptr] <= grant_q;
                slice_wr_ptr              <= ~slice_wr_ptr;
            end
            if (slice_rd) begin
                slice_rd_ptr <= ~slice_rd_ptr;
            end
            slice_cnt <= slice_cnt + {1'b0, slice_wr} - {1'b0, slice_rd};
        end
    end

    assign o_valid = (slice_cnt != 2'd0);
    assign o_flit  = o_valid ? slice_flit[slice_rd_ptr]  : '0;
    assign o_grant = o_valid ? slice_grant[slice_rd_ptr] : '0;
    assign o_ready = grant_q & {REQUESTERS{!slice_full}};
`else
    assign owner_acc = i_ready;
    assign o_valid   = owner_vld;
    assign o_flit    = owner_flit;
    assign o_grant   = grant_q;
    assign o_ready   = grant_q & {REQUESTERS{i_ready}};
`endif

endmodule

// File: tb/tb_tnoc_packet_arbiter.sv
// Scoreboard bench for tnoc_packet_arbiter with four requesters.
module tb_tnoc_packet_arbiter;
    import tnoc_packet_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int FW = 32;
`ifdef TNOC_PACKET_ARBITER_OUTPUT_SLICE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            i_clk;
    logic            i_rst;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    o_ready;
    logic [N*FW-1:0] i_flit;
    logic            o_valid;
    logic            i_ready;
    logic [FW-1:0]   o_flit;
    logic [N-1:0]    o_grant;
    logic            o_busy;

    tnoc_packet_arbiter #(
        .REQUESTERS (N),
        .FLIT_WIDTH (FW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_flit  (i_flit),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_flit  (o_flit),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [FW-1:0] src_q [N][$];
    logic [FW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_err    = 0;
    int            seq      = 0;
    logic          rdy_mode = 1'b0;
    logic          rdy_req  = 1'b1;
    logic          rdy_tog  = 1'b1;
    logic [N-1:0]  acc;
    logic [N-1:0]  one_n    = 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] make_flit(input int k, input int idx, input int len, input int s);
        logic [FW-1:0] f;
        f                = '0;
        f[FLIT_TYPE_BIT] = (idx == 0) ? FLIT_HEADER : FLIT_PAYLOAD;
        f[HEAD_BIT]      = (idx == 0);
        f[TAIL_BIT]      = (idx == len - 1);
        f[6:3]           = k[3:0];
        f[FW-1:7]        = s[FW-8:0];
        return f;
    endfunction

    task automatic send_pkt(input int k, input int len);
        logic [FW-1:0] f;
        for (int i = 0; i < len; i++) begin
            f = make_flit(k, i, len, seq);
            seq++;
            src_q[k].push_back(f);
            exp_q.push_back(f);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size();
        for (int k = 0; k < N; k++) p += src_q[k].size();
        return p;
    endfunction

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while (pending() != 0 && c < max_cycles) begin
            cyc(1);
            c++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        cyc(2);
    endtask

    // Requester sources and output monitor: sample on negedge, drive just after posedge.
    initial begin
        logic [FW-1:0] f;
        i_valid = '0;
        i_flit  = '0;
        i_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            acc = i_valid & o_ready;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", 64'(exp_q.size()), 64'd1);
                end else begin
                    f = exp_q.pop_front();
                    chk("flit", 64'(o_flit), 64'(f));
                    chk("grant_of_flit", 64'(o_grant), 64'(one_n << f[6:3]));
                end
            end
            @(posedge i_clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                i_valid[k]           = (src_q[k].size() > 0);
                i_flit[k*FW +: FW]   = (src_q[k].size() > 0) ? src_q[k][0] : '0;
            end
            if (rdy_mode) begin
                i_ready = rdy_tog;
                rdy_tog = ~rdy_tog;
            end else begin
                i_ready = rdy_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            order [5];
        logic [FW-1:0] f0;
        order = '{0, 1, 2, 3, 0};
        i_rst = 1'b1;
        cyc(2);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_flit",  64'(o_flit),  64'd0);
        i_rst = 1'b0;
        cyc(1);

        // Lone 3-flit packet from requester 0.
        send_pkt(0, 3);
        cyc(1);
        chk("t1_idle_grant", 64'(o_grant), 64'd0);
        cyc(1);
        chk("t1_busy", 64'(o_busy), 64'd1);
        cyc(LAT - 1);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) cyc(1);
            chk("t1_valid", 64'(o_valid), 64'd1);
            chk("t1_grant", 64'(o_grant), 64'b0001);
        end
        cyc(1);
        chk("t1_bubble_valid", 64'(o_valid), 64'd0);
        chk("t1_bubble_grant", 64'(o_grant), 64'd0);
        chk("t1_bubble_busy",  64'(o_busy),  64'd0);
        wait_drain(20);

        // Pointer is now 1: simultaneous req0/req1 must serve 1 first; then req3 alone wraps pointer to 0.
        send_pkt(1, 1);
        send_pkt(0, 1);
        wait_drain(20);
        send_pkt(3, 1);
        wait_drain(20);

        // All four requesting single-flit packets: order 0,1,2,3,0, one every 2 cycles.
        for (int j = 0; j < 5; j++) send_pkt(order[j], 1);
        cyc(1);
        cyc(LAT);
        for (int j = 0; j < 5; j++) begin
            chk("t2_valid", 64'(o_valid), 64'd1);
            chk("t2_grant", 64'(o_grant), 64'(one_n << order[j]));
            cyc(1);
            chk("t2_gap", 64'(o_valid), 64'd0);
            cyc(1);
        end
        wait_drain(20);

        // Requester 1 arrives while requester 0 holds the lock.
        send_pkt(0, 4);
        cyc(2);
        send_pkt(1, 1);
        for (int j = 0; j < 3; j++) begin
            cyc(1);
            chk("t3_ready1", 64'(o_ready[1]), 64'd0);
            chk("t3_ready0", 64'(o_ready[0]), 64'd1);
        end
        cyc(LAT);
        chk("t3_bubble", 64'(o_valid), 64'd0);
        cyc(1);
        chk("t3_grant1", 64'(o_grant), 64'b0010);
        chk("t3_valid1", 64'(o_valid), 64'd1);
        wait_drain(20);

        // Downstream stall for 5 cycles mid-packet with a competing requester.
        send_pkt(2, 4);
        send_pkt(3, 1);
        cyc(2);
        rdy_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            chk("t4_valid",  64'(o_valid),    64'd1);
            chk("t4_flit",   64'(o_flit),     64'(exp_q[0]));
            chk("t4_grant",  64'(o_grant),    64'b0100);
            chk("t4_ready3", 64'(o_ready[3]), 64'd0);
        end
        rdy_req = 1'b1;
        wait_drain(30);

        // Toggling downstream ready; first-flit latency.
        send_pkt(1, 4);
        f0       = exp_q[0];
        rdy_tog  = 1'b1;
        rdy_mode = 1'b1;
        cyc(LAT);
        chk("t5_lat_early", 64'(o_valid), 64'd0);
        cyc(1);
        chk("t5_lat_valid", 64'(o_valid), 64'd1);
        chk("t5_lat_flit",  64'(o_flit),  64'(f0));
        wait_drain(30);
        rdy_mode = 1'b0;
        cyc(2);

        // Reset during the second flit of a 4-flit packet; pointer must restart at 0.
        send_pkt(0, 4);
        cyc(1);
        cyc(LAT + 1);
        #1;
        i_rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(o_valid), 64'd0);
        chk("t6_rst_ready", 64'(o_ready), 64'd0);
        chk("t6_rst_grant", 64'(o_grant), 64'd0);
        chk("t6_rst_busy",  64'(o_busy),  64'd0);
        chk("t6_rst_flit",  64'(o_flit),  64'd0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        cyc(2);
        chk("t6_rst_hold", 64'(o_valid), 64'd0);
        i_rst = 1'b0;
        cyc(1);
        send_pkt(0, 1);
        send_pkt(1, 1);
        cyc(1);
        cyc(LAT);
        chk("t6_first_grant", 64'(o_grant), 64'b0001);
        wait_drain(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
